// File: rtl/xcorr_ssp_tx.sv
// xcorr_ssp_tx: buffers signed I/Q correlation byte pairs in a small FIFO
// and shifts each 16-bit word out MSB first over an SSP-style link
// (ssp_clk / active-low ssp_frame / ssp_din) to the ARM.
//
// Ports
//   ck_1356meg  in   sole clock, rising edge
//   rst         in   asynchronous active-high reset
//   corr_i      in   [7:0] in-phase byte, lands in word bits 15:8
//   corr_q      in   [7:0] quadrature byte, lands in word bits 7:0
//   corr_valid  in   one-cycle write strobe
//   tx_enable   in   permits the start of the next word transfer
//   corr_ready  out  FIFO has room
//   ssp_clk     out  serial clock, idles low
//   ssp_frame   out  active-low word frame
//   ssp_din     out  serial data, changes only as ssp_clk falls
//   overflow    out  sticky, a word was dropped on a full FIFO
//   fifo_level  out  FIFO occupancy
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | nothing to send, or sending blocked by tx_enable
// LOAD   | pop head word, frame low, present bit 15
// SHIFT  | 16 bits, each CLK_DIV cycles low then CLK_DIV cycles high
// GAP    | frame high / clock low for GAP_CYCLES before next word

module xcorr_ssp_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                          ck_1356meg,
    input  logic                          rst,
    input  logic [7:0]                    corr_i,
    input  logic [7:0]                    corr_q,
    input  logic                          corr_valid,
    input  logic                          tx_enable,
    output logic                          corr_ready,
    output logic                          ssp_clk,
    output logic                          ssp_frame,
    output logic                          ssp_din,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;

    localparam logic [LW-1:0] LVL_FULL   = LW'(FIFO_DEPTH);
    localparam logic [DW-1:0] DIV_RELOAD = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t        state_q;

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;

    // Bit 15 of the word goes straight to ssp_din at LOAD, so only the
    // remaining 15 bits need to be held for shifting.
    logic [14:0]   sreg_q;
    logic [3:0]    bit_q;
    logic [DW-1:0] div_q;
    logic [GW-1:0] gap_q;
    logic          clk_q;
    logic          frame_q;
    logic          din_q;

    logic          full;
    logic          push;
    logic          pop;
    logic          start_ok;
    logic [15:0]   head;

    // Room is judged on the registered level only: a pop in the same
    // cycle does not free a slot for a push into a full FIFO.
    assign full     = (level_q == LVL_FULL);
    assign push     = corr_valid && !full;
    assign pop      = (state_q == S_LOAD);
    assign start_ok = (level_q != '0) && tx_enable;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (corr_valid && full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge ck_1356meg) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {corr_i, corr_q};
        end
    end

    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            gap_q   <= '0;
            clk_q   <= 1'b0;
            frame_q <= 1'b1;
            din_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    sreg_q  <= head[14:0];
                    bit_q   <= '0;
                    div_q   <= DIV_RELOAD;
                    clk_q   <= 1'b0;
                    frame_q <= 1'b0;
                    din_q   <= head[15];
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (div_q != '0) begin
                        div_q <= div_q - DW'(1);
                    end else begin
                        div_q <= DIV_RELOAD;
                        if (!clk_q) begin
                            clk_q <= 1'b1;
                        end else begin
                            // Falling edge: the only point where ssp_din moves.
                            clk_q <= 1'b0;
                            if (bit_q == 4'd15) begin
                                frame_q <= 1'b1;
                                din_q   <= 1'b0;
                                gap_q   <= GAP_RELOAD;
                                state_q <= S_GAP;
                            end else begin
                                bit_q  <= bit_q + 4'd1;
                                din_q  <= sreg_q[14];
                                sreg_q <= {sreg_q[13:0], 1'b0};
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - GW'(1);
                    end else if (start_ok) begin
                        state_q <= S_LOAD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign corr_ready = !full;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign ssp_clk    = clk_q;
    assign ssp_frame  = frame_q;
    assign ssp_din    = din_q;

endmodule

// File: tb/tb_xcorr_ssp_tx.sv
module tb_xcorr_ssp_tx;

    localparam int DEPTH    = 4;
    localparam int PERIOD_A = 1 + 32 * 2 + 2;
    localparam int PERIOD_B = 1 + 32 * 1 + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] a_i, a_q, b_i, b_q;
    logic       a_valid, a_en, b_valid, b_en;
    logic       a_ready, a_sclk, a_frame, a_din, a_ovf;
    logic       b_ready, b_sclk, b_frame, b_din, b_ovf;
    logic [2:0] a_level, b_level;

    xcorr_ssp_tx #(.FIFO_DEPTH(DEPTH), .CLK_DIV(2), .GAP_CYCLES(2)) dut_a (
        .ck_1356meg(clk), .rst(rst), .corr_i(a_i), .corr_q(a_q),
        .corr_valid(a_valid), .tx_enable(a_en), .corr_ready(a_ready),
        .ssp_clk(a_sclk), .ssp_frame(a_frame), .ssp_din(a_din),
        .overflow(a_ovf), .fifo_level(a_level)
    );

    xcorr_ssp_tx #(.FIFO_DEPTH(DEPTH), .CLK_DIV(1), .GAP_CYCLES(1)) dut_b (
        .ck_1356meg(clk), .rst(rst), .corr_i(b_i), .corr_q(b_q),
        .corr_valid(b_valid), .tx_enable(b_en), .corr_ready(b_ready),
        .ssp_clk(b_sclk), .ssp_frame(b_frame), .ssp_din(b_din),
        .overflow(b_ovf), .fifo_level(b_level)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model for dut_a: accepted words in order, occupancy, sticky
    // overflow, plus a serial decoder of the link.
    int          m_level;
    bit          m_ovf;
    logic [15:0] sb_q[$];
    logic [15:0] rx_q[$];
    int          fall_q[$];
    logic        p_clk = 1'b0, p_frame = 1'b1, p_din = 1'b0, p_en = 1'b0;
    logic [15:0] dec_w;
    int          dec_n, low_cnt, last_rise, push_cyc;

    always @(posedge clk) begin
        logic fall, rise_f, c_rise, c_fall;
        #1;
        cyc++;
        if (rst) begin
            m_level = 0; m_ovf = 0; sb_q.delete();
            dec_n = 0; low_cnt = 0; last_rise = -100;
            chk("rst_level", 32'(a_level), 32'(0));
            chk("rst_ready", 32'(a_ready), 32'(1));
            chk("rst_sclk", 32'(a_sclk), 32'(0));
            chk("rst_frame", 32'(a_frame), 32'(1));
            chk("rst_din", 32'(a_din), 32'(0));
            chk("rst_ovf", 32'(a_ovf), 32'(0));
        end else begin
            fall   = p_frame && !a_frame;
            rise_f = !p_frame && a_frame;
            c_rise = !p_clk && a_sclk;
            c_fall = p_clk && !a_sclk;
            if (a_valid) begin
                if (m_level != DEPTH) begin
                    sb_q.push_back({a_i, a_q});
                    m_level++;
                    push_cyc = cyc;
                end else begin
                    m_ovf = 1;
                end
            end
            if (fall) m_level--;
            chk("level", 32'(a_level), 32'(m_level));
            chk("ready", 32'(a_ready), 32'(m_level != DEPTH));
            chk("overflow", 32'(a_ovf), 32'(m_ovf));
            if (a_frame) chk("sclk_idle_low", 32'(a_sclk), 32'(0));
            if (a_din !== p_din && !c_fall && !fall) chk("din_stable", 32'(a_din), 32'(p_din));
            if (fall) begin
                chk("load_needs_enable", 32'(p_en), 32'(1));
                chk("gap_min", 32'((cyc - last_rise) >= 3), 32'(1));
                dec_n = 0; low_cnt = 0;
                fall_q.push_back(cyc);
            end
            if (!a_frame) low_cnt++;
            if (c_rise) begin
                chk("sclk_rise_in_frame", 32'(a_frame), 32'(0));
                dec_w = {dec_w[14:0], a_din};
                dec_n++;
            end
            if (rise_f) begin
                last_rise = cyc;
                chk("bits_per_frame", 32'(dec_n), 32'(16));
                chk("frame_low_cycles", 32'(low_cnt), 32'(64));
                if (sb_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL word_unexpected: got 0x%h, want no frame", dec_w);
                end else begin
                    chk("word", 32'(dec_w), 32'(sb_q.pop_front()));
                end
                rx_q.push_back(dec_w);
            end
        end
        p_en = a_en; p_clk = a_sclk; p_frame = a_frame; p_din = a_din;
    end

    // Decoder for the fast-clock instance.
    logic        bp_clk = 1'b0, bp_frame = 1'b1, bp_din = 1'b0;
    logic [15:0] b_dec;
    int          b_n, b_low, b_cyc = 0;
    logic [15:0] b_rx[$];
    int          b_fall[$];

    always @(posedge clk) begin
        #1;
        b_cyc++;
        if (rst) begin
            b_n = 0; b_low = 0;
        end else begin
            if (b_din !== bp_din && !(bp_clk && !b_sclk) && !(bp_frame && !b_frame))
                chk("b_din_stable", 32'(b_din), 32'(bp_din));
            if (bp_frame && !b_frame) begin
                b_n = 0; b_low = 0; b_fall.push_back(b_cyc);
            end
            if (!b_frame) b_low++;
            if (!bp_clk && b_sclk) begin
                b_dec = {b_dec[14:0], b_din};
                b_n++;
            end
            if (!bp_frame && b_frame) begin
                chk("b_bits_per_frame", 32'(b_n), 32'(16));
                chk("b_frame_low_cycles", 32'(b_low), 32'(32));
                b_rx.push_back(b_dec);
            end
        end
        bp_clk = b_sclk; bp_frame = b_frame; bp_din = b_din;
    end

    task automatic push1(input logic [15:0] w);
        a_valid = 1'b1;
        {a_i, a_q} = w;
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rx(input int n, input int budget, input string name);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(rx_q.size()), 32'(n));
    endtask

    task automatic wait_fall(input int n, input int budget, input string name);
        int k = 0;
        while (fall_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(fall_q.size()), 32'(n));
    endtask

    typedef struct {
        logic [7:0]  i;
        logic [7:0]  q;
        logic [15:0] exp_word;
    } vec_t;

    vec_t        tbl[6];
    logic [15:0] b2b[4];

    initial begin
        int n0, f0, n1, f1, k;

        tbl[0] = '{8'hA5, 8'h3C, 16'hA53C};
        tbl[1] = '{8'h00, 8'h00, 16'h0000};
        tbl[2] = '{8'hFF, 8'hFF, 16'hFFFF};
        tbl[3] = '{8'h80, 8'h01, 16'h8001};
        tbl[4] = '{8'h7F, 8'hFE, 16'h7FFE};
        tbl[5] = '{8'h12, 8'h34, 16'h1234};
        b2b[0] = 16'h0102; b2b[1] = 16'h0304; b2b[2] = 16'h0506; b2b[3] = 16'h0708;

        a_valid = 0; a_en = 0; a_i = 0; a_q = 0;
        b_valid = 0; b_en = 0; b_i = 0; b_q = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single words; the first goes in on the first edge after reset.
        a_en = 1'b1;
        for (int t = 0; t < 6; t++) begin
            n0 = rx_q.size(); f0 = fall_q.size();
            push1({tbl[t].i, tbl[t].q});
            a_valid = 1'b0;
            wait_rx(n0 + 1, 200, "tbl_timeout");
            if (rx_q.size() > n0) chk("tbl_word", 32'(rx_q[n0]), 32'(tbl[t].exp_word));
            if (fall_q.size() > f0) chk("tbl_latency", 32'(fall_q[f0] - push_cyc), 32'(2));
            cycles(4);
        end

        // Back-to-back: fill while disabled, then release.
        a_en = 1'b0;
        n0 = rx_q.size(); f0 = fall_q.size();
        for (int t = 0; t < 4; t++) push1(b2b[t]);
        a_valid = 1'b0;
        cycles(2);
        chk("b2b_level_full", 32'(a_level), 32'(4));
        a_en = 1'b1;
        wait_rx(n0 + 4, 400, "b2b_timeout");
        if (rx_q.size() >= n0 + 4) begin
            for (int t = 0; t < 4; t++) begin
                chk("b2b_word", 32'(rx_q[n0 + t]), 32'(b2b[t]));
                if (t > 0) chk("b2b_spacing", 32'(fall_q[f0 + t] - fall_q[f0 + t - 1]), 32'(PERIOD_A));
            end
        end
        chk("b2b_no_overflow", 32'(a_ovf), 32'(0));
        cycles(4);

        // Overflow: five pushes into a disabled four-deep FIFO.
        a_en = 1'b0;
        n0 = rx_q.size();
        for (int t = 1; t <= 5; t++) push1(16'(16'h1111 * t));
        a_valid = 1'b0;
        cycles(2);
        chk("ovf_level", 32'(a_level), 32'(4));
        chk("ovf_ready", 32'(a_ready), 32'(0));
        chk("ovf_flag", 32'(a_ovf), 32'(1));
        a_en = 1'b1;
        wait_rx(n0 + 4, 400, "ovf_timeout");
        if (rx_q.size() >= n0 + 4) chk("ovf_last_kept", 32'(rx_q[n0 + 3]), 32'(16'h4444));
        cycles(150);
        chk("ovf_fifth_absent", 32'(rx_q.size()), 32'(n0 + 4));
        chk("ovf_sticky", 32'(a_ovf), 32'(1));

        // Enable gating mid-word.
        n0 = rx_q.size(); f0 = fall_q.size();
        push1(16'hC0DE);
        push1(16'hBEEF);
        a_valid = 1'b0;
        wait_fall(f0 + 1, 20, "gate_first_frame");
        cycles(20);
        a_en = 1'b0;
        wait_rx(n0 + 1, 200, "gate_word1_timeout");
        if (rx_q.size() > n0) chk("gate_word1", 32'(rx_q[n0]), 32'(16'hC0DE));
        cycles(100);
        chk("gate_frame_high", 32'(a_frame), 32'(1));
        chk("gate_no_new_frame", 32'(fall_q.size()), 32'(f0 + 1));
        chk("gate_level", 32'(a_level), 32'(1));
        a_en = 1'b1;
        wait_rx(n0 + 2, 200, "gate_word2_timeout");
        if (rx_q.size() > n0 + 1) chk("gate_word2", 32'(rx_q[n0 + 1]), 32'(16'hBEEF));
        cycles(4);

        // Reset in the middle of a word with another queued.
        f0 = fall_q.size();
        push1(16'h5A5A);
        push1(16'h1234);
        a_valid = 1'b0;
        wait_fall(f0 + 1, 20, "rst_frame_start");
        k = 0;
        while (dec_n < 7 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("rst_reached_bit7", 32'(dec_n), 32'(7));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async_frame", 32'(a_frame), 32'(1));
        chk("rst_async_sclk", 32'(a_sclk), 32'(0));
        chk("rst_async_level", 32'(a_level), 32'(0));
        cycles(3);
        rst = 1'b0;
        n1 = rx_q.size(); f1 = fall_q.size();
        cycles(200);
        chk("rst_no_resend", 32'(rx_q.size()), 32'(n1));
        chk("rst_no_frames", 32'(fall_q.size()), 32'(f1));
        chk("rst_ovf_cleared", 32'(a_ovf), 32'(0));

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            a_valid = ($urandom_range(0, 99) < 4);
            {a_i, a_q} = 16'($urandom);
            if ($urandom_range(0, 99) < 3) a_en = ~a_en;
            @(negedge clk);
        end
        a_valid = 1'b0;
        a_en = 1'b1;
        k = 0;
        while ((m_level != 0 || sb_q.size() != 0) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("drain_words_pending", 32'(sb_q.size()), 32'(0));
        chk("drain_level", 32'(a_level), 32'(0));

        // Fast instance: CLK_DIV=1, GAP_CYCLES=1.
        b_en = 1'b1;
        b_valid = 1'b1;
        {b_i, b_q} = 16'hFFFF;
        @(negedge clk);
        {b_i, b_q} = 16'h0000;
        @(negedge clk);
        b_valid = 1'b0;
        k = 0;
        while (b_rx.size() < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("b_word_count", 32'(b_rx.size()), 32'(2));
        if (b_rx.size() >= 2) begin
            chk("b_word0", 32'(b_rx[0]), 32'(16'hFFFF));
            chk("b_word1", 32'(b_rx[1]), 32'(16'h0000));
            chk("b_spacing", 32'(b_fall[1] - b_fall[0]), 32'(PERIOD_B));
        end
        chk("b_overflow", 32'(b_ovf), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule
